// File: rtl/inj_sched.sv
// inj_sched: injection scheduler sharing one router local-input port between
// N_SRC traffic-source ROM buffers (dataout_buf_*). Sources are granted
// round-robin in bursts of up to BURST words, with GAP idle cycles after each
// burst. The granted source's words are forwarded to the router with a
// registered output stage.
//
// Ports:
//   clk           clock
//   rst           synchronous active-low reset
//   start         1-cycle pulse, starts a run (only honoured in IDLE)
//   router_ready  router can accept; low pauses issue in the same cycle
//   src_dataout   source k word at [k*FLIT_W +: FLIT_W]
//   src_valid     per-source out_valid
//   src_enable    per-source enable, at most one bit high
//   flit_out      flit to router (holds last value when flit_valid=0)
//   flit_valid    flit_out valid
//   busy          high in SELECT/ISSUE/DRAIN/GAP
//   all_done      sticky, every source drained
//   err_stray     sticky, src_valid seen from a source that was not granted
module inj_sched #(
    parameter int N_SRC  = 4,
    parameter int FLIT_W = 20,
    parameter int WORDS  = 30,
    parameter int BURST  = 4,
    parameter int GAP    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    router_ready,
    input  logic [N_SRC*FLIT_W-1:0] src_dataout,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_enable,
    output logic [FLIT_W-1:0]       flit_out,
    output logic                    flit_valid,
    output logic                    busy,
    output logic                    all_done,
    output logic                    err_stray
);

    localparam int CW = $clog2(WORDS + 1);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_ISSUE, S_DRAIN, S_GAP, S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [SW-1:0]             rr_ptr, sel, pick, idx;
    logic [N_SRC-1:0][CW-1:0]  remaining;
    logic [N_SRC-1:0]          primed;
    logic [CW-1:0]             quota;
    logic [GW-1:0]             gap_cnt;
    logic                      found, en, last_word, in_xfer, fwd;
    logic [N_SRC-1:0]          own;
    int                        j;

    // Round-robin search from rr_ptr for the first source with words left.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N_SRC; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_SRC) j = j - N_SRC;
            idx = SW'(j);
            if (!found && remaining[idx] != '0) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign en        = (state == S_ISSUE) && router_ready;
    // The first enable of a source only primes it, so it never ends a burst.
    assign last_word = en && primed[sel] && (quota == CW'(1));
    // Valid data from the granted source may arrive in ISSUE and one cycle later in DRAIN.
    assign in_xfer   = (state == S_ISSUE) || (state == S_DRAIN);
    assign fwd       = in_xfer && src_valid[sel];

    always_comb begin
        src_enable = '0;
        if (en) src_enable[sel] = 1'b1;
    end

    always_comb begin
        own = '0;
        if (in_xfer) own[sel] = 1'b1;
    end

    assign busy     = (state == S_SELECT) || (state == S_ISSUE) ||
                      (state == S_DRAIN)  || (state == S_GAP);
    assign all_done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SELECT;
            S_SELECT: state_nxt = found ? S_ISSUE : S_DONE;
            S_ISSUE:  if (last_word) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = (GAP > 0) ? S_GAP : S_SELECT;
            S_GAP:    if (gap_cnt <= GW'(1)) state_nxt = S_SELECT;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            sel        <= '0;
            quota      <= '0;
            gap_cnt    <= '0;
            primed     <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            err_stray  <= 1'b0;
            for (int k = 0; k < N_SRC; k++) remaining[k] <= CW'(WORDS);
        end else begin
            state <= state_nxt;
            case (state)
                S_SELECT: begin
                    if (found) begin
                        sel <= pick;
                        if (int'(remaining[pick]) < BURST) quota <= remaining[pick];
                        else                               quota <= CW'(BURST);
                    end
                end
                S_ISSUE: begin
                    if (en) begin
                        if (!primed[sel]) begin
                            primed[sel] <= 1'b1;
                        end else begin
                            if (quota != '0)          quota          <= quota - 1'b1;
                            if (remaining[sel] != '0) remaining[sel] <= remaining[sel] - 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    rr_ptr  <= (sel == SW'(N_SRC - 1)) ? '0 : sel + 1'b1;
                    gap_cnt <= GW'(GAP);
                end
                S_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase

            flit_valid <= fwd;
            if (fwd) flit_out <= src_dataout[sel*FLIT_W +: FLIT_W];
            if (|(src_valid & ~own)) err_stray <= 1'b1;
        end
    end

endmodule
